// File: rtl/pattern_scan_pkg.sv
// Shared types for the "1101" scan controller and its bit-serial detector.
// Pure declarations; no timing or flow-control behaviour of its own.
package pattern_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN,
    DONE
  } ctrl_state_t;

  typedef enum logic [2:0] {
    S0,
    S1,
    S11,
    S110,
    S1101
  } det_state_t;

  localparam logic [3:0] PATTERN = 4'b1101;

  // States are named by the longest suffix of the input that is still a pattern prefix.
  function automatic det_state_t det_next(input det_state_t cur, input logic bit_i);
    case (cur)
      S0:      return bit_i ? S1    : S0;
      S1:      return bit_i ? S11   : S0;
      S11:     return bit_i ? S11   : S110;
      S110:    return bit_i ? S1101 : S0;
      S1101:   return bit_i ? S11   : S0;
      default: return S0;
    endcase
  endfunction

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Word-in / count-out handshake bundle between producer, scan controller and consumer.
// Both directions are valid/ready; abort rides alongside the input side.
interface pattern_scan_ctrl_if #(
  parameter int WIDTH = 16
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] match_cnt;
  logic             match_any;

  modport master (
    output in_valid, in_data, abort, out_ready,
    input  in_ready, out_valid, match_cnt, match_any
  );

  modport slave (
    input  in_valid, in_data, abort, out_ready,
    output in_ready, out_valid, match_cnt, match_any
  );

endinterface

// File: rtl/seq_detect_1101.sv
// Moore "1101" detector, overlapping matches; det_o follows the matching bit by one cycle.
// Advances only while det_en is high; det_clr forces S0 and wins over det_i.
module seq_detect_1101
  import pattern_scan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic det_clr,
  input  logic det_en,
  input  logic det_i,
  output logic det_o
);

  det_state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S0;
      det_o <= 1'b0;
    end else if (det_clr) begin
      state <= S0;
      det_o <= 1'b0;
    end else if (det_en) begin
      state <= det_next(state, det_i);
      det_o <= (det_next(state, det_i) == S1101);
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Accepts a word, scans it MSB-first through the 1101 detector, returns the match count.
// Result valid WIDTH+2 cycles after accept; DONE holds the result until out_ready, in_ready low meanwhile.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  pattern_scan_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  ctrl_state_t      state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bitcnt;
  logic [CNT_W-1:0] match_cnt;
  logic             in_ready_q;
  logic             out_valid_q;

  logic accept;
  logic det_clr;
  logic det_en;
  logic det_i;
  logic det_o;

  // Clearing on the accept edge itself leaves the detector in S0 for the first SHIFT bit.
  assign accept  = bus.in_valid && in_ready_q;
  assign det_clr = accept;
  assign det_en  = (state == SHIFT);
  assign det_i   = shreg[WIDTH-1];

  seq_detect_1101 u_det (
    .clk     (clk),
    .rst     (rst),
    .det_clr (det_clr),
    .det_en  (det_en),
    .det_i   (det_i),
    .det_o   (det_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bitcnt      <= '0;
      match_cnt   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg      <= bus.in_data;
            bitcnt     <= '0;
            match_cnt  <= '0;
            in_ready_q <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.abort) begin
            match_cnt  <= '0;
            in_ready_q <= 1'b1;
            state      <= IDLE;
          end else begin
            shreg  <= {shreg[WIDTH-2:0], 1'b0};
            bitcnt <= bitcnt + CNT_W'(1);
            if (det_o) match_cnt <= match_cnt + CNT_W'(1);
            if (bitcnt == LAST_BIT) state <= DRAIN;
          end
        end
        // One extra cycle to see the detector's response to the final bit.
        DRAIN: begin
          if (bus.abort) begin
            match_cnt  <= '0;
            in_ready_q <= 1'b1;
            state      <= IDLE;
          end else begin
            if (det_o) match_cnt <= match_cnt + CNT_W'(1);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.match_cnt = match_cnt;
  assign bus.match_any = (match_cnt != '0);

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: directed table, handshake corner sequences, random words vs a window-count model.
module tb_pattern_scan_ctrl;
  import pattern_scan_pkg::*;

  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pcyc = 0;
  int   acc_cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  pattern_scan_ctrl_if #(.WIDTH(WIDTH)) bus ();

  pattern_scan_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcyc <= pcyc + 1;

  typedef struct {
    logic [WIDTH-1:0] word;
    int               exp_cnt;
    int               stall;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Count every 4-bit window equal to the pattern; windows may overlap.
  function automatic int ref_count(input logic [WIDTH-1:0] w);
    int c = 0;
    for (int i = WIDTH - 1; i >= 3; i--)
      if (w[i -: 4] == PATTERN) c++;
    return c;
  endfunction

  // Called at a negedge; returns at the negedge after the result handshake.
  task automatic run_word(input logic [WIDTH-1:0] w, input int stall, input int exp_cnt, input string tag);
    int t;
    int lat;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, " ready_before"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    @(negedge clk);
    acc_cyc      = pcyc;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(WIDTH + 2));
    check({tag, " match_cnt"}, 32'(bus.match_cnt), 32'(exp_cnt));
    check({tag, " match_any"}, 32'(bus.match_any), 32'(exp_cnt != 0));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, " stall_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, " stall_cnt"}, 32'(bus.match_cnt), 32'(exp_cnt));
      check({tag, " stall_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, " ready_after"}, 32'(bus.in_ready), 32'd1);
    check({tag, " valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  // Interrupt a scan in SHIFT cycle at_cycle by abort or by reset; no result may follow.
  task automatic cut_scan(input bit use_rst, input int at_cycle, input string tag);
    int seen;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hDB6D;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int c = 1; c < at_cycle; c++) @(negedge clk);
    if (use_rst) rst = 1'b1;
    else         bus.abort = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    bus.abort = 1'b0;
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, " match_cnt"}, 32'(bus.match_cnt), 32'd0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    check({tag, " no_result"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] pat;
    int               prev_acc;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;

    tbl[0] = '{16'hD000, 1, 0};
    tbl[1] = '{16'hDB6D, 5, 0};
    tbl[2] = '{16'h000D, 1, 0};
    tbl[3] = '{16'hFFFF, 0, 0};
    tbl[4] = '{16'h0006, 0, 0};
    tbl[5] = '{16'h8000, 0, 0};
    tbl[6] = '{16'hDDDD, 4, 5};
    tbl[7] = '{16'h0000, 0, 0};

    repeat (3) @(negedge clk);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset match_cnt", 32'(bus.match_cnt), 32'd0);
    check("reset match_any", 32'(bus.match_any), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    prev_acc = 0;
    for (int i = 0; i < 8; i++) begin
      run_word(tbl[i].word, tbl[i].stall, tbl[i].exp_cnt, $sformatf("vec%0d", i));
      if (i > 0 && tbl[i-1].stall == 0)
        check($sformatf("vec%0d throughput", i), 32'(acc_cyc - prev_acc), 32'(WIDTH + 3));
      prev_acc = acc_cyc;
    end

    // Abort is a no-op in IDLE.
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("idle_abort in_ready", 32'(bus.in_ready), 32'd1);

    cut_scan(1'b0, 6, "abort");
    run_word(16'hD000, 0, 1, "post_abort");
    cut_scan(1'b1, 10, "mid_rst");
    run_word(16'hD000, 0, 1, "post_rst");

    for (int n = 0; n < 40; n++) begin
      w = WIDTH'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        pat = 16'h000D;
        w = w | (pat << $urandom_range(0, 12));
      end
      run_word(w, $urandom_range(0, 2), ref_count(w), $sformatf("rand%0d_%h", n, w));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
